// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the pipelined ALU.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_AND    = 3'd2,
      OP_OR     = 3'd3,
      OP_XOR    = 3'd4,
      OP_SLT    = 3'd5,
      OP_SATADD = 3'd6,
      OP_SATSUB = 3'd7
   } op_e;

   localparam int FLG_OVF   = 0;
   localparam int FLG_CARRY = 1;
   localparam int FLG_ZERO  = 2;
   localparam int FLG_NEG   = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one operation to result plus {neg,zero,carry,ovf}.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  op_e              op_i,
   output logic [WIDTH-1:0] res_o,
   output logic [3:0]       flags_o
);

   localparam int M = WIDTH - 1;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {M{1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {M{1'b0}}};

   logic [WIDTH:0]   sum, dif;
   logic             add_ovf, sub_ovf, slt;
   logic [WIDTH-1:0] res;
   logic             carry, ovf;

   assign sum     = {1'b0, a_i} + {1'b0, b_i};
   assign dif     = {1'b0, a_i} - {1'b0, b_i};
   assign add_ovf = (a_i[M] == b_i[M]) && (sum[M] != a_i[M]);
   assign sub_ovf = (a_i[M] != b_i[M]) && (dif[M] != a_i[M]);
   assign slt     = $signed(a_i) < $signed(b_i);

   // On signed overflow the true result has the sign of A, so A's sign picks the clamp rail.
   always_comb begin
      res   = '0;
      carry = 1'b0;
      ovf   = 1'b0;
      case (op_i)
         OP_ADD: begin
            res   = sum[M:0];
            carry = sum[WIDTH];
            ovf   = add_ovf;
         end
         OP_SUB: begin
            res   = dif[M:0];
            carry = dif[WIDTH];
            ovf   = sub_ovf;
         end
         OP_AND: res = a_i & b_i;
         OP_OR:  res = a_i | b_i;
         OP_XOR: res = a_i ^ b_i;
         OP_SLT: res = {{M{1'b0}}, slt};
         OP_SATADD: begin
            res   = (SAT_EN && add_ovf) ? (a_i[M] ? SMIN : SMAX) : sum[M:0];
            carry = sum[WIDTH];
            ovf   = add_ovf;
         end
         OP_SATSUB: begin
            res   = (SAT_EN && sub_ovf) ? (a_i[M] ? SMIN : SMAX) : dif[M:0];
            carry = dif[WIDTH];
            ovf   = sub_ovf;
         end
         default: ;
      endcase
   end

   assign res_o              = res;
   assign flags_o[FLG_NEG]   = res[M];
   assign flags_o[FLG_ZERO]  = (res == '0);
   assign flags_o[FLG_CARRY] = carry;
   assign flags_o[FLG_OVF]   = ovf;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipe: S1 captures operands, S2 computes and holds the result.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags,
   output logic [WIDTH-1:0] acc
);

   logic             s1_valid_q, s1_accsel_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   op_e              s1_op_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_q, acc_q;
   logic [3:0]       flags_q;

   logic             s2_free, s1_move, in_fire;
   logic [WIDTH-1:0] opa, res_d;
   logic [3:0]       flags_d;

   assign s2_free  = !out_valid_q || out_ready;
   assign s1_move  = s1_valid_q && s2_free;
   assign in_ready = !s1_valid_q || s2_free;
   assign in_fire  = in_valid && in_ready;

   // acc is read at the S1->S2 move, so a back-to-back accumulate sees the previous result.
   assign opa = s1_accsel_q ? acc_q : s1_a_q;

   alu_core #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_core (
      .a_i     (opa),
      .b_i     (s1_b_q),
      .op_i    (s1_op_q),
      .res_o   (res_d),
      .flags_o (flags_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_accsel_q <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_op_q     <= OP_ADD;
      end else if (in_fire) begin
         s1_valid_q  <= 1'b1;
         s1_accsel_q <= acc_sel;
         s1_a_q      <= a;
         s1_b_q      <= b;
         s1_op_q     <= op_e'(op);
      end else if (s1_move) begin
         s1_valid_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         flags_q     <= '0;
         acc_q       <= '0;
      end else begin
         if (s2_free) out_valid_q <= s1_valid_q;
         if (s1_move) begin
            out_q   <= res_d;
            flags_q <= flags_d;
            if (s1_accsel_q) acc_q <= res_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign flags     = flags_q;
   assign acc       = acc_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, two-stage pipelined successor to the single-cycle 8-bit add/sub ALU.
- Adds a multi-operation set, optional saturation, status flags and a running accumulator.
- Uses valid/ready handshakes on both sides so it can sit between streaming producers and consumers in the datapath.
- Back-pressure stalls the pipe without dropping or duplicating transactions.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
SAT_EN, 1, 1 = SATADD/SATSUB opcodes saturate; 0 = they behave as ADD/SUB

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  input transaction valid
in_ready  output  1  block can accept input this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
op  input  3  opcode (see package)
acc_sel  input  1  1 = substitute accumulator for operand A
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
out  output  WIDTH  result
flags  output  4  {neg, zero, carry, ovf} of result
acc  output  WIDTH  current accumulator value

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - Registered outputs cleared: out_valid=0, out=0, flags=0, acc=0.
  - Stage-1 valid cleared.
  - in_ready=1 is combinational and therefore reads 1 while in reset.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - out, flags and out_valid are held stable while out_valid&&!out_ready.
- Pipeline:
  - S1 registers {a, b, op, acc_sel}.
  - S2 computes from the S1 registers and registers out/flags.
  - Latency 2 cycles input-transfer to out_valid; throughput 1 per cycle with out_ready=1.
- Advance and ready:
  - s2_free = !out_valid || out_ready.
  - S1->S2 move when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free (combinational, no skid buffer).
- Opcodes:
  - ADD=0: A+B. SUB=1: A-B. AND=2, OR=3, XOR=4.
  - SLT=5: signed A<B gives 1, else 0.
  - SATADD=6 / SATSUB=7: signed saturating add/sub, clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Arithmetic is modulo 2^WIDTH except the saturating ops.
- Operand A: A = acc_sel ? acc : a, with acc sampled at S1->S2 move time.
- Accumulator:
  - acc <= computed result on every S1->S2 move whose acc_sel=1; unchanged otherwise.
  - Back-to-back accumulate transactions are therefore correct with no forwarding.
- Flags:
  - neg = result MSB; zero = (result==0).
  - carry: carry-out for ADD/SATADD; borrow (A<B unsigned) for SUB/SATSUB; 0 for other ops.
  - ovf = signed overflow of the unsaturated add/sub; 0 for logic ops and SLT.
  - For saturating ops, ovf=1 exactly when clamping occurred.
- Boundaries:
  - Simultaneous input transfer and output transfer in a full pipe: all stages advance, no bubble.
  - in_valid with in_ready=0 is ignored; the producer holds its inputs.
  - rst_n low mid-transaction discards in-flight data and clears acc.

Decomposition:
- Package alu_pkg holds the op_e typedef (3-bit enum, values above) and the flag bit-index constants FLG_OVF=0, FLG_CARRY=1, FLG_ZERO=2, FLG_NEG=3.
- Sub-module alu_core: purely combinational (A, B, op, SAT_EN) -> (result, flags), instantiated in S2.
- The handshake and pipeline registers stay in alu_pipe.

Test Plan:
- WIDTH=8, out_ready=1: stream ADD a=i, b=i for i=0..9 back-to-back -> out=2i, each appearing exactly 2 cycles after its input transfer, one result per cycle.
- SUB a=1, b=2 -> out=0xFF, flags neg=1, carry=1, ovf=0. ADD a=0x7F, b=1 -> out=0x80, ovf=1, neg=1.
- SATADD a=0x7F, b=0x10 -> 0x7F, ovf=1. SATSUB a=0x80, b=1 -> 0x80, ovf=1. Rerun with SAT_EN=0 -> 0x8F and 0x7F respectively.
- acc_sel=1, ADD b=3 issued 4 times back-to-back -> outs 3, 6, 9, 12; acc=12 at the end.
- out_ready=0 for 5 cycles while streaming -> in_ready falls after 2 accepted inputs, out held stable. Releasing out_ready -> all inputs emerge in order, none lost or duplicated.
- Assert rst_n low with 2 transactions in flight and acc=12 -> out_valid=0 and acc=0 immediately, without waiting for a clock edge. The first post-reset input produces the correct result with latency 2.
